// File: rtl/sha_256_pad_pkg.sv
// sha_const: state encoding, register record and padding helpers for sha_256_pad.
package sha_const;
    typedef enum logic [2:0] {IDLE, FILL, PAD, SEND, WAIT} state_t;
    typedef struct packed {
        state_t      state;
        logic [3:0]  p;
        logic        pad_pending;
        logic        length_pending;
        logic        is_final;
        logic [63:0] len;
    } reg_type;
    localparam logic [31:0] PAD_WORD = 32'h8000_0000;
    localparam reg_type REG_RESET = '{state: IDLE, p: 4'd0, pad_pending: 1'b0,
                                      length_pending: 1'b0, is_final: 1'b0, len: 64'd0};
    function automatic logic [31:0] pad_word(input logic [31:0] word, input logic [2:0] bytes);
        return bytes == 3'd4 ? word
                             : (word & ~(32'hFFFF_FFFF >> {bytes, 3'b000})) | (PAD_WORD >> {bytes, 3'b000});
    endfunction
endpackage

// File: rtl/sha_256_pad_if.sv
// sha_256_pad_if: message stream, core block port and digest outputs of sha_256_pad.
interface sha_256_pad_if;
    logic [31:0]  s_data;
    logic [2:0]   s_bytes;
    logic         s_last;
    logic         s_valid;
    logic         s_ready;
    logic [1:0]   mode;
    logic [511:0] Data;
    logic [63:0]  Index;
    logic [1:0]   Operation;
    logic         Enable;
    logic         Ready;
    logic [255:0] Hash;
    logic [255:0] digest;
    logic         digest_valid;
    logic         busy;
    modport slave (input s_data, s_bytes, s_last, s_valid, mode, Ready, Hash,
                   output s_ready, Data, Index, Operation, Enable, digest, digest_valid, busy);
    modport master (output s_data, s_bytes, s_last, s_valid, mode, Ready, Hash,
                    input s_ready, Data, Index, Operation, Enable, digest, digest_valid, busy);
endinterface

// File: rtl/sha_256_pad.sv
// sha_256_pad: FIPS 180-4 padder and block sequencer for the SHA-224/256 core.
// Define SHA_PAD_SHA224_EN to honour mode; otherwise Operation is fixed at 1 (SHA-256).
module sha_256_pad
    import sha_const::*;
(
    input  logic          clk,
    input  logic          rst,
    sha_256_pad_if.slave  io_bus
);
    reg_type             r_s, w_s;
    logic [15:0][31:0]   r_data, w_data;
    logic [63:0]         r_index, w_index;
    logic [1:0]          r_op, w_op;
    logic [255:0]        r_digest, w_digest;
    logic                r_dv, w_dv;
    logic                w_take;
    logic [2:0]          w_b;
    logic [3:0]          w_pos;

    assign io_bus.s_ready      = rst && (r_s.state == IDLE || r_s.state == FILL);
    assign io_bus.Data         = r_data;
    assign io_bus.Index        = r_index;
    assign io_bus.Operation    = r_op;
    assign io_bus.Enable       = r_s.state == SEND;
    assign io_bus.digest       = r_digest;
    assign io_bus.digest_valid = r_dv;
    assign io_bus.busy         = r_s.state != IDLE;

    assign w_take = io_bus.s_valid && io_bus.s_ready;
    assign w_b    = (!io_bus.s_last || io_bus.s_bytes > 3'd4) ? 3'd4 : io_bus.s_bytes;
    assign w_pos  = r_s.state == IDLE ? 4'd0 : r_s.p;

    always_comb begin
        w_s      = r_s;
        w_data   = r_data;
        w_index  = r_index;
        w_op     = r_op;
        w_digest = r_digest;
        w_dv     = 1'b0;
        case (r_s.state)
            IDLE, FILL: if (w_take) begin
                if (r_s.state == IDLE) begin
                    w_index = 64'd0;
`ifdef SHA_PAD_SHA224_EN
                    w_op = io_bus.mode;
`endif
                end
                w_s.len            = (r_s.state == IDLE ? 64'd0 : r_s.len) + {58'd0, w_b, 3'd0};
                w_data[w_pos]      = pad_word(io_bus.s_data, w_b);
                w_s.p              = w_pos + 4'd1;
                w_s.pad_pending    = io_bus.s_last && w_b == 3'd4;
                // A 0x80 byte landing in word 14 or 15 leaves no room for the length.
                w_s.length_pending = io_bus.s_last && w_b != 3'd4 && w_pos >= 4'd14;
                w_s.is_final       = 1'b0;
                w_s.state          = w_pos == 4'd15 ? SEND : io_bus.s_last ? PAD : FILL;
            end
            PAD: begin
                w_data[r_s.p]      = r_s.pad_pending ? PAD_WORD
                                   : (r_s.p == 4'd14 && !r_s.length_pending) ? r_s.len[63:32]
                                   : (r_s.p == 4'd15 && !r_s.length_pending) ? r_s.len[31:0]
                                   : 32'd0;
                w_s.pad_pending    = 1'b0;
                w_s.length_pending = r_s.length_pending || (r_s.pad_pending && r_s.p >= 4'd14);
                w_s.is_final       = r_s.p == 4'd15 && !w_s.length_pending;
                w_s.p              = r_s.p + 4'd1;
                w_s.state          = r_s.p == 4'd15 ? SEND : PAD;
            end
            SEND: w_s.state = WAIT;
            WAIT: if (io_bus.Ready) begin
                w_index            = r_index + 64'd1;
                w_s.p              = 4'd0;
                w_s.length_pending = 1'b0;
                w_digest           = r_s.is_final ? io_bus.Hash : r_digest;
                w_dv               = r_s.is_final;
                w_s.state          = r_s.is_final ? IDLE
                                   : (r_s.pad_pending || r_s.length_pending) ? PAD : FILL;
            end
            default: w_s.state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s      <= REG_RESET;
            r_data   <= '0;
            r_index  <= 64'd0;
            r_op     <= 2'd1;
            r_digest <= 256'd0;
            r_dv     <= 1'b0;
        end else begin
            r_s      <= w_s;
            r_data   <= w_data;
            r_index  <= w_index;
            r_op     <= w_op;
            r_digest <= w_digest;
            r_dv     <= w_dv;
        end
    end
endmodule

// File: tb/tb_sha_256_pad.sv
// tb_sha_256_pad: padding reference plus a behavioural SHA-256 core checking sha_256_pad.
`timescale 1ns/1ps
module tb_sha_256_pad;
    typedef logic [7:0] bq_t[$];
    typedef struct {
        string        msg;
        logic [1:0]   mode;
        bit           has_known;
        logic [255:0] dig;
    } vec_t;

    localparam logic [255:0] IV256 = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] IV224 = 256'hc1059ed8367cd5073070dd17f70e5939ffc00b316858151164f98fa7befa4fa4;
    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   fails = 0;
    logic [511:0] cap_data[$];
    logic [63:0]  cap_idx[$];
    logic [1:0]   cap_op[$];
    int           cap_cyc[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sha_256_pad_if bus();
    sha_256_pad dut (.clk(clk), .rst(rst), .io_bus(bus));

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2;
        logic [255:0] res;
        for (int i = 0; i < 16; i++) w[i] = blk[i*32 +: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + w[i-7] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3))
                 + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        for (int i = 0; i < 8; i++) v[i] = hin[255-32*i -: 32];
        for (int i = 0; i < 64; i++) begin
            t1 = v[7] + (ror(v[4], 6) ^ ror(v[4], 11) ^ ror(v[4], 25)) + ((v[4] & v[5]) ^ (~v[4] & v[6])) + K[i] + w[i];
            t2 = (ror(v[0], 2) ^ ror(v[0], 13) ^ ror(v[0], 22)) + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            v[7] = v[6]; v[6] = v[5]; v[5] = v[4]; v[4] = v[3] + t1;
            v[3] = v[2]; v[2] = v[1]; v[1] = v[0]; v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) res[255-32*i -: 32] = hin[255-32*i -: 32] + v[i];
        return res;
    endfunction

    function automatic bq_t s2b(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    task automatic check(input bit cond, input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (!cond) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural core: chains compressions, answers each Enable with a Ready after a random delay.
    initial begin
        int dly;
        bit pend;
        logic [255:0] chain;
        dly = 0; pend = 1'b0; chain = '0;
        bus.Ready = 1'b0;
        bus.Hash  = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                pend = 1'b0;
                bus.Ready = 1'b0;
            end else if (bus.Ready) begin
                bus.Ready = 1'b0;
                bus.Hash  = {8{$urandom}};
            end else if (bus.Enable) begin
                cap_data.push_back(bus.Data);
                cap_idx.push_back(bus.Index);
                cap_op.push_back(bus.Operation);
                cap_cyc.push_back(cyc);
                chain = compress(bus.Index == 64'd0 ? (bus.Operation == 2'd0 ? IV224 : IV256) : chain, bus.Data);
                dly = $urandom_range(1, 4);
                pend = 1'b1;
            end else if (pend) begin
                dly--;
                if (dly == 0) begin
                    bus.Ready = 1'b1;
                    bus.Hash  = chain;
                    pend = 1'b0;
                end
            end
        end
    end

    task automatic send_msg(input bq_t m, input logic [1:0] md, output int last_acc, output int last_p, output bit ok);
        int nw;
        int b;
        nw = m.size() == 0 ? 1 : (m.size() + 3) / 4;
        b = m.size() % 4 == 0 ? (m.size() == 0 ? 0 : 4) : m.size() % 4;
        ok = 1'b1;
        last_acc = 0;
        last_p = (nw - 1) % 16;
        for (int i = 0; i < nw; i++) begin
            logic [31:0] wd;
            int tmo;
            if ($urandom_range(0, 3) == 0) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
            wd = $urandom;
            for (int j = 0; j < 4; j++) if (4*i + j < m.size()) wd[31-8*j -: 8] = m[4*i + j];
            bus.s_data  = wd;
            bus.s_last  = i == nw - 1;
            bus.s_bytes = i == nw - 1 ? 3'(b) : 3'($urandom_range(0, 7));
            bus.mode    = i == 0 ? md : 2'($urandom);
            bus.s_valid = 1'b1;
            tmo = 0;
            while (!bus.s_ready && tmo < 100) begin
                @(negedge clk);
                tmo++;
            end
            if (tmo == 100) begin
                ok = 1'b0;
                bus.s_valid = 1'b0;
                return;
            end
            last_acc = cyc;
            @(negedge clk);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic run_msg(input string name, input bq_t m, input logic [1:0] md, input bit has_known, input logic [255:0] known);
        bq_t pb;
        logic [511:0] eb[$];
        logic [255:0] chain;
        logic [1:0] eop;
        logic [63:0] bits;
        int acc, lp, tmo, lat;
        bit ok;
`ifdef SHA_PAD_SHA224_EN
        eop = md;
`else
        eop = 2'd1;
`endif
        pb = m;
        bits = 64'(m.size()) * 64'd8;
        pb.push_back(8'h80);
        while (pb.size() % 64 != 56) pb.push_back(8'h00);
        for (int i = 7; i >= 0; i--) pb.push_back(bits[8*i +: 8]);
        for (int k = 0; k < pb.size() / 64; k++) begin
            logic [511:0] blk;
            for (int w = 0; w < 16; w++)
                blk[w*32 +: 32] = {pb[64*k + 4*w], pb[64*k + 4*w + 1], pb[64*k + 4*w + 2], pb[64*k + 4*w + 3]};
            eb.push_back(blk);
        end
        chain = eop == 2'd0 ? IV224 : IV256;
        foreach (eb[i]) chain = compress(chain, eb[i]);
        cap_data.delete(); cap_idx.delete(); cap_op.delete(); cap_cyc.delete();
        send_msg(m, md, acc, lp, ok);
        check(ok, {name, " accept"}, 512'(ok), 512'd1);
        tmo = 0;
        while (!bus.digest_valid && tmo < 3000) begin
            @(negedge clk);
            tmo++;
        end
        check(tmo < 3000, {name, " digest_valid timeout"}, 512'(tmo), 512'd3000);
        if (tmo < 3000) begin
            check(bus.busy == 1'b0, {name, " busy at digest_valid"}, 512'(bus.busy), 512'd0);
            check(bus.digest == chain, {name, " digest"}, 512'(bus.digest), 512'(chain));
            if (has_known)
                check(eop == 2'd0 ? bus.digest[255:32] == known[255:32] : bus.digest == known,
                      {name, " known digest"}, 512'(bus.digest), 512'(known));
            @(negedge clk);
            check(!bus.digest_valid, {name, " digest_valid width"}, 512'(bus.digest_valid), 512'd0);
        end
        check(cap_data.size() == eb.size(), {name, " block count"}, 512'(cap_data.size()), 512'(eb.size()));
        for (int i = 0; i < eb.size() && i < cap_data.size(); i++) begin
            check(cap_data[i] == eb[i], {name, " block data"}, cap_data[i], eb[i]);
            check(cap_idx[i] == 64'(i), {name, " Index"}, 512'(cap_idx[i]), 512'(i));
            check(cap_op[i] == eop, {name, " Operation"}, 512'(cap_op[i]), 512'(eop));
        end
        lat = -1;
        foreach (cap_cyc[i]) if (lat < 0 && cap_cyc[i] > acc) lat = cap_cyc[i] - acc;
        check(lat == 16 - lp, {name, " Enable latency"}, 512'(lat), 512'(16 - lp));
    endtask

    initial begin
        vec_t vecs[$];
        int acc, lp;
        bit ok, dv_seen;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_bytes = '0; bus.s_last = 1'b0; bus.mode = 2'd1;
        vecs.push_back('{msg: "abc", mode: 2'd1, has_known: 1'b1,
            dig: 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad});
        vecs.push_back('{msg: "", mode: 2'd1, has_known: 1'b1,
            dig: 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855});
        vecs.push_back('{msg: "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", mode: 2'd1, has_known: 1'b1,
            dig: 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1});
        vecs.push_back('{msg: "abcdefghijklmnopqrstuvwxyzABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789+/", mode: 2'd1,
            has_known: 1'b0, dig: 256'd0});
`ifdef SHA_PAD_SHA224_EN
        vecs.push_back('{msg: "abc", mode: 2'd0, has_known: 1'b1,
            dig: {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'd0}});
`endif
        repeat (3) @(negedge clk);
        check(bus.s_ready == 1'b0, "reset s_ready", 512'(bus.s_ready), 512'd0);
        check(bus.Enable == 1'b0, "reset Enable", 512'(bus.Enable), 512'd0);
        check(bus.digest_valid == 1'b0, "reset digest_valid", 512'(bus.digest_valid), 512'd0);
        check(bus.busy == 1'b0, "reset busy", 512'(bus.busy), 512'd0);
        check(bus.digest == 256'd0, "reset digest", 512'(bus.digest), 512'd0);
        check(bus.Data == 512'd0, "reset Data", bus.Data, 512'd0);
        check(bus.Index == 64'd0, "reset Index", 512'(bus.Index), 512'd0);
        check(bus.Operation == 2'd1, "reset Operation", 512'(bus.Operation), 512'd1);
        rst = 1'b1;
        @(negedge clk);
        check(bus.s_ready == 1'b1, "idle s_ready", 512'(bus.s_ready), 512'd1);

        foreach (vecs[v]) begin
            bq_t m;
            m = s2b(vecs[v].msg);
            run_msg($sformatf("vec%0d", v), m, vecs[v].mode, vecs[v].has_known, vecs[v].dig);
            if (m.size() == 3 && cap_data.size() > 0)
                check(cap_data[0][511:480] == 32'h18, "abc word15 length", 512'(cap_data[0][511:480]), 512'h18);
            if (m.size() == 64 && cap_data.size() > 1) begin
                check(cap_data[1][31:0] == 32'h8000_0000, "64B block1 word0", 512'(cap_data[1][31:0]), 512'h8000_0000);
                check(cap_data[1][511:480] == 32'h200, "64B block1 word15", 512'(cap_data[1][511:480]), 512'h200);
            end
        end

        for (int len = 49; len <= 68; len++) begin
            bq_t m;
            for (int k = 0; k < len; k++) m.push_back(8'($urandom));
            run_msg($sformatf("len%0d", len), m, 2'($urandom_range(0, 1)), 1'b0, 256'd0);
        end
        for (int r = 0; r < 10; r++) begin
            bq_t m;
            int len;
            len = $urandom_range(0, 140);
            for (int k = 0; k < len; k++) m.push_back(8'($urandom));
            run_msg($sformatf("rand%0d_len%0d", r, len), m, 2'($urandom_range(0, 1)), 1'b0, 256'd0);
        end

        // Abort a message while its block is with the core.
        send_msg(s2b("abc"), 2'd1, acc, lp, ok);
        check(ok, "abort accept", 512'(ok), 512'd1);
        dv_seen = 1'b0;
        for (int t = 0; t < 100 && !bus.Enable; t++) @(negedge clk);
        check(bus.Enable == 1'b1, "abort Enable seen", 512'(bus.Enable), 512'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (bus.digest_valid) dv_seen = 1'b1;
        end
        check(bus.s_ready == 1'b0, "abort s_ready in reset", 512'(bus.s_ready), 512'd0);
        check(bus.busy == 1'b0, "abort busy", 512'(bus.busy), 512'd0);
        check(bus.digest == 256'd0, "abort digest cleared", 512'(bus.digest), 512'd0);
        rst = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (bus.digest_valid) dv_seen = 1'b1;
        end
        check(!dv_seen, "abort no digest_valid", 512'(dv_seen), 512'd0);
        run_msg("after abort", s2b("abc"), 2'd1, 1'b1,
                256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
